// File: rtl/grv_dispatch_ctrl.sv
// Gaussian sample dispatcher: warm-up discard, 8-entry pair FIFO, 2-consumer round-robin.
// Optional GRV_SIGMA_SCALE_EN adds per-consumer Q4.4 sigma scaling of out_data.
module grv_dispatch_ctrl (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    output logic               rng_enable,
    input  logic signed [15:0] rng_grv1,
    input  logic signed [15:0] rng_grv2,
    input  logic               rng_valid,
    input  logic [1:0]         req,
`ifdef GRV_SIGMA_SCALE_EN
    input  logic [7:0]         sigma0,
    input  logic [7:0]         sigma1,
`endif
    output logic [1:0]         out_grant,
    output logic signed [15:0] out_data,
    output logic [3:0]         fifo_level,
    output logic               overflow
);

    localparam logic [0:0] WARMUP = 1'b0;
    localparam logic [0:0] RUN    = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [1:0]       wcnt, wcnt_nxt;
    logic [7:0][15:0] mem;
    logic [2:0]       rd_ptr, wr_ptr;
    logic [3:0]       level_nxt;
    logic             rr_ptr, gsel;
    logic             run, pop, push, drop;
    logic signed [15:0] sample, disp;

    assign run    = (state == RUN);
    assign sample = $signed(mem[rd_ptr]);

    always_comb begin
        gsel = rr_ptr;
        if (!req[rr_ptr]) gsel = ~rr_ptr;
        // Pop and free-space decisions both use the pre-push, pre-pop level.
        pop  = run && (fifo_level != 4'd0) && (req != 2'b00) && !flush;
        push = run && rng_valid && (fifo_level <= 4'd6) && !flush;
        drop = run && rng_valid && (fifo_level > 4'd6) && !flush;
        level_nxt = fifo_level + {2'b00, push, 1'b0} - {3'b000, pop};
        if (flush) level_nxt = 4'd0;
        state_nxt = state;
        wcnt_nxt  = wcnt;
        if (flush) begin
            state_nxt = WARMUP;
            wcnt_nxt  = 2'd0;
        end else if (!run && rng_valid) begin
            wcnt_nxt = wcnt + 2'd1;
            if (wcnt == 2'd3) state_nxt = RUN;
        end
    end

`ifdef GRV_SIGMA_SCALE_EN
    logic [7:0]         sig;
    logic signed [24:0] prod, shf;
    always_comb begin
        sig  = gsel ? sigma1 : sigma0;
        prod = sample * $signed({1'b0, sig});
        shf  = prod >>> 4;
        if (shf > 25'sd32767)       disp = 16'sh7FFF;
        else if (shf < -25'sd32768) disp = 16'sh8000;
        else                        disp = shf[15:0];
    end
`else
    assign disp = sample;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]        <= rng_grv1;
            mem[wr_ptr + 3'd1] <= rng_grv2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WARMUP;
            wcnt       <= 2'd0;
            fifo_level <= 4'd0;
            rd_ptr     <= 3'd0;
            wr_ptr     <= 3'd0;
            rng_enable <= 1'b0;
            out_grant  <= 2'b00;
            out_data   <= 16'sd0;
            overflow   <= 1'b0;
            rr_ptr     <= 1'b0;
        end else begin
            state      <= state_nxt;
            wcnt       <= wcnt_nxt;
            fifo_level <= level_nxt;
            rng_enable <= (state_nxt == WARMUP) || (level_nxt <= 4'd4);
            out_grant  <= pop ? (gsel ? 2'b10 : 2'b01) : 2'b00;
            if (pop) out_data <= disp;
            if (drop) overflow <= 1'b1;
            if (flush) begin
                rd_ptr <= 3'd0;
                wr_ptr <= 3'd0;
                rr_ptr <= 1'b0;
            end else begin
                if (pop)  rd_ptr <= rd_ptr + 3'd1;
                if (push) wr_ptr <= wr_ptr + 3'd2;
                // Next priority goes to the consumer after the one just served.
                if (pop)  rr_ptr <= ~gsel;
            end
        end
    end

endmodule

// File: tb/tb_grv_dispatch_ctrl.sv
// Directed bench for grv_dispatch_ctrl; scaling checks follow GRV_SIGMA_SCALE_EN.
module tb_grv_dispatch_ctrl;

    logic               clk = 1'b0;
    logic               reset, flush, rng_valid;
    logic signed [15:0] rng_grv1, rng_grv2;
    logic [1:0]         req;
    logic               rng_enable, overflow;
    logic [1:0]         out_grant;
    logic signed [15:0] out_data;
    logic [3:0]         fifo_level;
`ifdef GRV_SIGMA_SCALE_EN
    logic [7:0]         sigma0, sigma1;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    grv_dispatch_ctrl dut (
        .clk(clk), .reset(reset), .flush(flush), .rng_enable(rng_enable),
        .rng_grv1(rng_grv1), .rng_grv2(rng_grv2), .rng_valid(rng_valid), .req(req),
`ifdef GRV_SIGMA_SCALE_EN
        .sigma0(sigma0), .sigma1(sigma1),
`endif
        .out_grant(out_grant), .out_data(out_data), .fifo_level(fifo_level),
        .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic signed [15:0] a, input logic signed [15:0] b);
        rng_valid = 1'b1; rng_grv1 = a; rng_grv2 = b;
        tick();
        rng_valid = 1'b0;
    endtask

    initial begin
`ifdef GRV_SIGMA_SCALE_EN
        sigma0 = 8'h20; sigma1 = 8'h10;
`endif
        reset = 1'b1; flush = 1'b0; rng_valid = 1'b0; req = 2'b00;
        rng_grv1 = 16'sd0; rng_grv2 = 16'sd0;
        #23;
        chk("rst_en",    16'(rng_enable), 16'd0);
        chk("rst_level", 16'(fifo_level), 16'd0);
        chk("rst_grant", 16'(out_grant),  16'd0);
        chk("rst_data",  16'(out_data),   16'd0);
        chk("rst_ovf",   16'(overflow),   16'd0);
        @(negedge clk); reset = 1'b0;
        tick();
        chk("en_after_rst", 16'(rng_enable), 16'd1);

        // Warm-up: four pairs discarded, fifth stored.
        pair(16'sd1, 16'sd2); pair(16'sd3, 16'sd4); pair(16'sd5, 16'sd6);
        chk("warm_level3", 16'(fifo_level), 16'd0);
        pair(16'sd7, 16'sd8);
        chk("warm_level4", 16'(fifo_level), 16'd0);
        chk("warm_grant",  16'(out_grant),  16'd0);
        pair(16'sd9, 16'sd10);
        chk("warm_level5", 16'(fifo_level), 16'd2);
        req = 2'b10;
        tick();
        chk("warm_g1", 16'(out_grant), 16'd2);
        chk("warm_d1", 16'(out_data),  16'd9);
        tick();
        chk("warm_d2", 16'(out_data),  16'd10);
        chk("warm_lv0", 16'(fifo_level), 16'd0);
        req = 2'b00;
        tick();
        chk("idle_grant", 16'(out_grant), 16'd0);
        chk("idle_hold",  16'(out_data),  16'd10);

        // Round-robin over two requesters.
        pair(16'sd100, 16'sd200); pair(16'sd300, 16'sd400);
        chk("rr_level", 16'(fifo_level), 16'd4);
        req = 2'b11;
        tick(); chk("rr_g1", 16'(out_grant), 16'd1); chk("rr_d1", 16'(out_data), 16'd100);
        tick(); chk("rr_g2", 16'(out_grant), 16'd2); chk("rr_d2", 16'(out_data), 16'd200);
        tick(); chk("rr_g3", 16'(out_grant), 16'd1); chk("rr_d3", 16'(out_data), 16'd300);
        tick(); chk("rr_g4", 16'(out_grant), 16'd2); chk("rr_d4", 16'(out_data), 16'd400);
        tick(); chk("rr_g5", 16'(out_grant), 16'd0); chk("rr_hold", 16'(out_data), 16'd400);
        chk("rr_lv0", 16'(fifo_level), 16'd0);

        // Push and request on an empty FIFO in the same cycle.
        req = 2'b01;
        pair(-16'sd3, 16'sd4);
        chk("pp_grant", 16'(out_grant),  16'd0);
        chk("pp_level", 16'(fifo_level), 16'd2);
        tick();
        chk("pp_g", 16'(out_grant), 16'd1);
        chk("pp_d", 16'(out_data),  -16'sd3);
        chk("pp_lv", 16'(fifo_level), 16'd1);
        tick();
        chk("pp_d2", 16'(out_data), 16'd4);
        req = 2'b00;
        tick();

        // Overflow: reach level 7, then a pair must be dropped.
        pair(16'sd11, 16'sd12); pair(16'sd13, 16'sd14); pair(16'sd15, 16'sd16);
        chk("of_lv6", 16'(fifo_level), 16'd6);
        chk("of_en6", 16'(rng_enable), 16'd0);
        req = 2'b01;
        pair(16'sd17, 16'sd18);
        req = 2'b00;
        chk("of_lv7", 16'(fifo_level), 16'd7);
        chk("of_d11", 16'(out_data),   16'd11);
        chk("of_ovf0", 16'(overflow),  16'd0);
        pair(16'sd5, 16'sd6);
        chk("of_lv7b", 16'(fifo_level), 16'd7);
        chk("of_ovf1", 16'(overflow),   16'd1);
        req = 2'b01;
        tick();
        req = 2'b00;
        chk("of_d12", 16'(out_data),   16'd12);
        chk("of_lv6b", 16'(fifo_level), 16'd6);

        // Flush at level 6 beats a same-cycle push and request.
        flush = 1'b1; req = 2'b01;
        pair(16'sd50, 16'sd51);
        flush = 1'b0; req = 2'b00;
        chk("fl_level", 16'(fifo_level), 16'd0);
        chk("fl_grant", 16'(out_grant),  16'd0);
        chk("fl_ovf",   16'(overflow),   16'd1);
        chk("fl_en",    16'(rng_enable), 16'd1);
        pair(16'sd1, 16'sd1); pair(16'sd2, 16'sd2); pair(16'sd3, 16'sd3); pair(16'sd4, 16'sd4);
        chk("fl_disc", 16'(fifo_level), 16'd0);
        pair(16'sd21, 16'sd22);
        chk("fl_lv2", 16'(fifo_level), 16'd2);
        req = 2'b11;
        tick();
        req = 2'b00;
        chk("fl_g", 16'(out_grant), 16'd1);
        chk("fl_d", 16'(out_data),  16'd21);
        chk("ovf_sticky", 16'(overflow), 16'd1);

        // Reset mid-operation clears samples and overflow.
        reset = 1'b1; #3;
        chk("rst2_ovf",   16'(overflow),   16'd0);
        chk("rst2_level", 16'(fifo_level), 16'd0);
        @(negedge clk); reset = 1'b0;
        tick();
        pair(16'sd1, 16'sd2); pair(16'sd3, 16'sd4); pair(16'sd5, 16'sd6); pair(16'sd7, 16'sd8);
        pair(16'sd20000, -16'sd1000);
        req = 2'b01;
        tick();
`ifdef GRV_SIGMA_SCALE_EN
        chk("sc_sat", 16'(out_data), 16'sd32767);
`else
        chk("sc_raw1", 16'(out_data), 16'sd20000);
`endif
        tick();
`ifdef GRV_SIGMA_SCALE_EN
        chk("sc_neg", 16'(out_data), -16'sd2000);
`else
        chk("sc_raw2", 16'(out_data), -16'sd1000);
`endif
        req = 2'b00;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
